// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with built-in baud divider.
//
// Frame: start(0), DATA_BITS data bits LSB first, optional parity bit,
// one or two stop bits(1). Frame settings are captured at the handshake, so
// input changes after accept do not affect the frame in flight.
//
// Parameters:
//   DATA_BITS     data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset (aborts any frame, TXD=1)
//   tx_data      payload, captured on accept
//   tx_valid     client has data
//   tx_ready     block can accept (high only in IDLE)
//   parity_mode  00/11 none, 01 even, 10 odd; captured on accept
//   stop2        1 = two stop bits; captured on accept
//   break_req    (only with UART_TX_BREAK_EN) request a line break
//   busy         high whenever not IDLE
//   TXD          serial line, idle/mark = 1
//
// Optional feature macro: UART_TX_BREAK_EN adds break_req and a BREAK state.
// Break holds TXD low for at least one 8N1-style frame time
// (CLKS_PER_BIT*(DATA_BITS+2) cycles), then one stop bit period of mark.

module uart_tx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_req,
`endif
    output logic                 busy,
    output logic                 TXD
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_BREAK_EN
    localparam int unsigned BRK_CYC = CLKS_PER_BIT * (DATA_BITS + 2);
    localparam int unsigned BRK_W   = $clog2(BRK_CYC);
    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BRK_CYC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        , BREAK
`endif
    } state_t;

    state_t               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 ready_q;
`ifdef UART_TX_BREAK_EN
    logic [BRK_W-1:0]     brk_q;
`endif

    logic baud_done;
    assign baud_done = (baud_q == BAUD_LAST);

    assign TXD      = txd_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef UART_TX_BREAK_EN
            brk_q     <= '0;
`endif
        end else begin
            // Baud counter restarts on every bit boundary and stays at 0 in IDLE.
            if (state_q == IDLE || baud_done) baud_q <= '0;
            else                              baud_q <= baud_q + 1'b1;

            unique case (state_q)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        state_q <= BREAK;
                        brk_q   <= '0;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else
`endif
                    if (tx_valid) begin
                        state_q   <= START;
                        shift_q   <= tx_data;
                        par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        par_bit_q <= (^tx_data) ^ (parity_mode == 2'b10);
                        stop2_q   <= stop2;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (par_en_q) begin
                                state_q <= PARITY;
                                txd_q   <= par_bit_q;
                            end else begin
                                state_q <= STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            // Next bit is presented from shift_q[1] as the register shifts.
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_done) begin
                        state_q <= STOP;
                        bit_q   <= '0;
                        txd_q   <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        // bit_q counts completed stop bits when two are requested.
                        if (stop2_q && bit_q == '0) begin
                            bit_q <= BIT_W'(1);
                        end else begin
                            state_q <= IDLE;
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (brk_q != BRK_LAST) brk_q <= brk_q + 1'b1;
                    if (!break_req && brk_q == BRK_LAST) begin
                        // Reuse STOP for the single trailing mark bit.
                        state_q <= STOP;
                        bit_q   <= '0;
                        stop2_q <= 1'b0;
                        txd_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two instances (DATA_BITS=8 and 5, CLKS_PER_BIT=4)
// driven from a table of frames with hand-derived TXD bit strings, plus
// sequences for back-to-back transfer, mid-frame reset and (optionally) break.

module tb_uart_tx_param;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       reset;

    logic [7:0] tx_data8;
    logic       tx_valid8, stop2_8, ready8, busy8, txd8;
    logic [1:0] pm8;

    logic [4:0] tx_data5;
    logic       tx_valid5, stop2_5, ready5, busy5, txd5;
    logic [1:0] pm5;

`ifdef UART_TX_BREAK_EN
    logic       break_req8 = 1'b0;
    logic       break_req5 = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut8 (
        .clk(clk), .reset(reset), .tx_data(tx_data8), .tx_valid(tx_valid8),
        .tx_ready(ready8), .parity_mode(pm8), .stop2(stop2_8),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req8),
`endif
        .busy(busy8), .TXD(txd8)
    );

    uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB)) dut5 (
        .clk(clk), .reset(reset), .tx_data(tx_data5), .tx_valid(tx_valid5),
        .tx_ready(ready5), .parity_mode(pm5), .stop2(stop2_5),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req5),
`endif
        .busy(busy5), .TXD(txd5)
    );

    typedef struct {
        string      nm;
        int         sel;
        logic [8:0] d;
        logic [1:0] pm;
        logic       s2;
        string      exp;   // TXD per bit period, in time order
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic [8:0] d, input logic [1:0] pm,
                         input logic s2, input logic v);
        if (sel == 8) begin
            tx_data8 = d[7:0]; pm8 = pm; stop2_8 = s2; tx_valid8 = v;
        end else begin
            tx_data5 = d[4:0]; pm5 = pm; stop2_5 = s2; tx_valid5 = v;
        end
    endtask

    function automatic logic [2:0] outs(input int sel);
        return (sel == 8) ? {txd8, busy8, ready8} : {txd5, busy5, ready5};
    endfunction

    // Starts at a negedge in IDLE; ends at the negedge of the IDLE cycle after the frame.
    task automatic run_frame(input vec_t v, input logic hold, input logic [8:0] d_next);
        logic [2:0] o;
        logic       e;
        drive(v.sel, v.d, v.pm, v.s2, 1'b1);
        @(posedge clk);
        #1;
        drive(v.sel, d_next, ~v.pm, ~v.s2, hold);
        for (int i = 0; i < v.exp.len(); i++) begin
            e = (v.exp.getc(i) == 8'h31);
            for (int c = 0; c < int'(CPB); c++) begin
                @(negedge clk);
                o = outs(v.sel);
                chk($sformatf("%s bit%0d TXD", v.nm, i), 9'(o[2]), 9'(e));
                chk($sformatf("%s bit%0d busy/ready", v.nm, i), 9'(o[1:0]), 9'b10);
            end
        end
        @(negedge clk);
        o = outs(v.sel);
        chk($sformatf("%s end idle", v.nm), 9'(o), 9'b101);
    endtask

    initial begin
        vec_t w;
        logic [2:0] o;

        vecs[0] = '{"a5_even",   8, 9'h0A5, 2'b01, 1'b0, "01010010101"};
        vecs[1] = '{"07_odd",    8, 9'h007, 2'b10, 1'b0, "01110000001"};
        vecs[2] = '{"03_odd",    8, 9'h003, 2'b10, 1'b0, "01100000011"};
        vecs[3] = '{"ff_none_s2",8, 9'h0FF, 2'b00, 1'b1, "01111111111"};
        vecs[4] = '{"5a_pm11",   8, 9'h05A, 2'b11, 1'b0, "0010110101"};
        vecs[5] = '{"01_even_s2",8, 9'h001, 2'b01, 1'b1, "010000000111"};
        vecs[6] = '{"d5_1f",     5, 9'h1FF, 2'b01, 1'b0, "01111111"};
        vecs[7] = '{"d5_12",     5, 9'h012, 2'b01, 1'b0, "00100101"};

        reset = 1'b1;
        drive(8, 9'h0, 2'b00, 1'b0, 1'b0);
        drive(5, 9'h0, 2'b00, 1'b0, 1'b0);
        #3;
        chk("reset dut8 txd/busy/ready", 9'(outs(8)), 9'b101);
        chk("reset dut5 txd/busy/ready", 9'(outs(5)), 9'b101);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle after reset", 9'(outs(8)), 9'b101);

        for (int k = 0; k < 8; k++) run_frame(vecs[k], 1'b0, 9'h155);

        // Back-to-back with tx_valid held high: one IDLE cycle between frames.
        w = '{"b2b_55", 8, 9'h055, 2'b01, 1'b0, "01010101001"};
        run_frame(w, 1'b1, 9'h0AA);
        w = '{"b2b_aa", 8, 9'h0AA, 2'b01, 1'b0, "00101010101"};
        run_frame(w, 1'b0, 9'h000);

        // Reset in the middle of data bit 3 of a 0x3C frame.
        drive(8, 9'h03C, 2'b01, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(8, 9'h0C3, 2'b10, 1'b1, 1'b0);
        repeat (18) @(negedge clk);
        chk("pre-reset busy", 9'(busy8), 9'd1);
        reset = 1'b1;
        #1;
        o = outs(8);
        chk("mid-frame reset txd/busy/ready", 9'(o), 9'b101);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        w = '{"post_reset_3c", 8, 9'h03C, 2'b01, 1'b0, "00011110001"};
        run_frame(w, 1'b0, 9'h1FF);

`ifdef UART_TX_BREAK_EN
        break_req8 = 1'b1;
        drive(8, 9'h0FF, 2'b01, 1'b0, 1'b1);   // break has priority over valid
        @(posedge clk);
        #1;
        drive(8, 9'h0FF, 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk($sformatf("break low %0d", k), 9'(outs(8)), 9'b010);
            if (k == 99) break_req8 = 1'b0;
        end
        for (int k = 0; k < int'(CPB); k++) begin
            @(negedge clk);
            chk($sformatf("break mark %0d", k), 9'(outs(8)), 9'b110);
        end
        @(negedge clk);
        chk("break end idle", 9'(outs(8)), 9'b101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
